// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request/response and RAM strobe bundle for mem_access_ctrl
interface mem_access_ctrl_if;
    // CPU request side
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_mode;
    logic        req_signed;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    // CPU response side
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] rdata;
    // RAM side
    logic        Enable;
    logic        ReadWrite;
    logic [7:0]  Address;
    logic [31:0] DataIn;
    logic [1:0]  Mode;
    logic        MOC;
    logic [31:0] DataOut;

    // CPU and RAM environment around the controller
    modport master (
        output req_valid, req_write, req_mode, req_signed, req_addr, req_wdata,
        output MOC, DataOut,
        input  busy, done, err, rdata,
        input  Enable, ReadWrite, Address, DataIn, Mode
    );

    // The controller itself
    modport slave (
        input  req_valid, req_write, req_mode, req_signed, req_addr, req_wdata,
        input  MOC, DataOut,
        output busy, done, err, rdata,
        output Enable, ReadWrite, Address, DataIn, Mode
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-request initiator for the ram256x8 Enable/MOC handshake
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             Clk,
    input  logic             Reset,
    mem_access_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_RELEASE, S_DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_write;
    logic [1:0]    r_mode;
    logic          r_signed;
    logic          r_dword;
    logic          r_beat2;
    logic [31:0]   r_wdata_lo;
    logic [31:0]   r_rd_hi;

    logic          w_cnt_last;
    logic [63:0]   w_rd_ext;
    logic [31:0]   w_beat1_data;

    assign w_cnt_last = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Align and extend the RAM read word for single-beat reads
    always_comb begin
        w_rd_ext = {32'b0, bus.DataOut};
        case (r_mode)
            2'b00:   w_rd_ext = r_signed ? {{56{bus.DataOut[7]}}, bus.DataOut[7:0]}
                                         : {56'b0, bus.DataOut[7:0]};
            2'b01:   w_rd_ext = r_signed ? {{48{bus.DataOut[15]}}, bus.DataOut[15:0]}
                                         : {48'b0, bus.DataOut[15:0]};
            default: w_rd_ext = {32'b0, bus.DataOut};
        endcase
    end

    // First-beat write data, right-justified and zero-padded by size
    always_comb begin
        w_beat1_data = bus.req_wdata[31:0];
        case (bus.req_mode)
            2'b00:   w_beat1_data = {24'b0, bus.req_wdata[7:0]};
            2'b01:   w_beat1_data = {16'b0, bus.req_wdata[15:0]};
            2'b10:   w_beat1_data = bus.req_wdata[31:0];
            default: w_beat1_data = bus.req_wdata[63:32];
        endcase
    end

    // Transaction FSM; every output is registered here
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_write       <= 1'b0;
            r_mode        <= 2'b00;
            r_signed      <= 1'b0;
            r_dword       <= 1'b0;
            r_beat2       <= 1'b0;
            r_wdata_lo    <= 32'b0;
            r_rd_hi       <= 32'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.rdata     <= 64'b0;
            bus.Enable    <= 1'b0;
            bus.ReadWrite <= 1'b1;
            bus.Address   <= 8'b0;
            bus.DataIn    <= 32'b0;
            bus.Mode      <= 2'b00;
        end else begin
            bus.done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_write       <= bus.req_write;
                        r_mode        <= bus.req_mode;
                        r_signed      <= bus.req_signed;
                        r_dword       <= (bus.req_mode == 2'b11);
                        r_beat2       <= 1'b0;
                        r_wdata_lo    <= bus.req_wdata[31:0];
                        r_cnt         <= '0;
                        bus.busy      <= 1'b1;
                        bus.err       <= 1'b0;
                        bus.Enable    <= 1'b1;
                        bus.ReadWrite <= ~bus.req_write;
                        bus.Address   <= bus.req_addr;
                        // A dword travels as two word beats
                        bus.Mode      <= (bus.req_mode == 2'b11) ? 2'b10 : bus.req_mode;
                        bus.DataIn    <= w_beat1_data;
                        r_state       <= S_ASSERT;
                    end
                end
                S_ASSERT: begin
                    if (bus.MOC) begin
                        bus.Enable <= 1'b0;
                        r_cnt      <= '0;
                        if (!r_write) begin
                            // Hold the first dword half until beat 2 succeeds
                            if (r_dword && !r_beat2) r_rd_hi   <= bus.DataOut;
                            else if (r_dword)        bus.rdata <= {r_rd_hi, bus.DataOut};
                            else                     bus.rdata <= w_rd_ext;
                        end
                        if (r_dword && !r_beat2) begin
                            r_state <= S_RELEASE;
                        end else begin
                            bus.done <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end else if (w_cnt_last) begin
                        bus.Enable <= 1'b0;
                        bus.err    <= 1'b1;
                        bus.done   <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!bus.MOC) begin
                        bus.Enable  <= 1'b1;
                        bus.Address <= bus.Address + 8'd4;
                        bus.DataIn  <= r_wdata_lo;
                        r_beat2     <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_ASSERT;
                    end else if (w_cnt_last) begin
                        bus.err  <= 1'b1;
                        bus.done <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a behavioural ram256x8
module tb_mem_access_ctrl;
    localparam int T = 8;

    logic Clk;
    logic Reset;
    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    typedef struct {
        logic        err;
        logic [63:0] rdata;
        int          lat;
    } resp_t;

    typedef struct {
        logic [7:0]  addr;
        logic        rw;
        logic [1:0]  mode;
        logic [31:0] data;
    } beat_t;

    resp_t sb[$];
    beat_t beat_q[$];

    logic [7:0]  ram_mem [256];
    logic [7:0]  ref_mem [256];
    logic [63:0] ref_rdata;
    int tests;
    int fails;
    int cyc;
    int acc_cyc;
    int moc_delay, rel_delay;
    bit stuck_asr, stuck_rel;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},      64'(bus.busy),      64'd0);
        check({tag, "_done"},      64'(bus.done),      64'd0);
        check({tag, "_err"},       64'(bus.err),       64'd0);
        check({tag, "_rdata"},     bus.rdata,          64'd0);
        check({tag, "_enable"},    64'(bus.Enable),    64'd0);
        check({tag, "_readwrite"}, 64'(bus.ReadWrite), 64'd1);
        check({tag, "_address"},   64'(bus.Address),   64'd0);
        check({tag, "_datain"},    64'(bus.DataIn),    64'd0);
        check({tag, "_mode"},      64'(bus.Mode),      64'd0);
    endtask

    // Behavioural ram256x8: big-endian bytes, MOC after a programmable delay
    initial begin : ram_model
        int acnt, rcnt, nb;
        logic [7:0]  a;
        logic [31:0] v, junk;
        acnt = 0;
        rcnt = 0;
        bus.MOC = 1'b0;
        bus.DataOut = 32'b0;
        forever begin
            @(negedge Clk);
            if (bus.MOC) begin
                if (!bus.Enable && !stuck_rel) begin
                    if (rcnt >= rel_delay) begin bus.MOC = 1'b0; rcnt = 0; end
                    else rcnt++;
                end
            end else if (bus.Enable && !stuck_asr) begin
                if (acnt >= moc_delay) begin
                    a  = bus.Address;
                    nb = (bus.Mode == 2'b00) ? 1 : (bus.Mode == 2'b01) ? 2 : 4;
                    if (!bus.ReadWrite) begin
                        for (int k = 0; k < nb; k++) ram_mem[a + 8'(k)] = bus.DataIn[8*(nb-1-k) +: 8];
                    end else begin
                        v = 32'b0;
                        for (int k = 0; k < nb; k++) v = {v[23:0], ram_mem[a + 8'(k)]};
                        junk = $urandom;
                        if (nb == 1)      bus.DataOut = {junk[31:8], v[7:0]};
                        else if (nb == 2) bus.DataOut = {junk[31:16], v[15:0]};
                        else              bus.DataOut = v;
                    end
                    bus.MOC = 1'b1;
                    acnt = 0;
                end else acnt++;
            end else acnt = 0;
        end
    end

    // Beat monitor: every rising Enable must match the next expected beat
    initial begin : beat_mon
        logic prev_en;
        beat_t b;
        prev_en = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Reset && bus.Enable && !prev_en) begin
                if (beat_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_beat: got addr %0h expected none", bus.Address);
                end else begin
                    b = beat_q.pop_front();
                    check("beat_addr", 64'(bus.Address), 64'(b.addr));
                    check("beat_rw",   64'(bus.ReadWrite), 64'(b.rw));
                    check("beat_mode", 64'(bus.Mode), 64'(b.mode));
                    if (!b.rw) check("beat_datain", 64'(bus.DataIn), 64'(b.data));
                end
            end
            prev_en = Reset ? 1'b0 : bus.Enable;
        end
    end

    // Response monitor: every done pulse pops one scoreboard entry
    initial begin : resp_mon
        resp_t r;
        forever begin
            @(negedge Clk);
            if (!Reset && bus.done) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got done=1 expected no transaction");
                end else begin
                    r = sb.pop_front();
                    check("resp_err",   64'(bus.err), 64'(r.err));
                    check("resp_rdata", bus.rdata, r.rdata);
                    check("resp_busy",  64'(bus.busy), 64'd1);
                    check("resp_latency", 64'(cyc - acc_cyc), 64'(r.lat));
                end
            end
        end
    end

    task automatic do_txn(input logic wr, input logic [1:0] mode, input logic sgn,
                          input logic [7:0] addr, input logic [63:0] wdata,
                          input int d, input int rd, input bit sa, input bit sr,
                          input bit hold, input bit rst_b2);
        int n, nw, lat, i;
        logic [63:0] val;
        logic [31:0] mask;
        beat_t b;
        resp_t r;
        n = (mode == 2'b00) ? 1 : (mode == 2'b01) ? 2 : (mode == 2'b10) ? 4 : 8;
        // Wait for an idle controller and a released RAM
        for (i = 0; i < 60 && (bus.busy || bus.MOC); i++) @(negedge Clk);
        if (i == 60) begin tests++; fails++; $display("FAIL idle_wait: got busy/MOC high expected idle"); end
        moc_delay = d; rel_delay = rd; stuck_asr = sa; stuck_rel = sr;

        // Reference model: a transfer is n consecutive bytes from addr
        if (wr) begin
            nw = sa ? 0 : (sr ? 4 : n);
            for (int k = 0; k < nw; k++) ref_mem[addr + 8'(k)] = wdata[8*(n-1-k) +: 8];
        end else if (!sa && !sr && !rst_b2) begin
            val = 64'b0;
            for (int k = 0; k < n; k++) val = {val[55:0], ref_mem[addr + 8'(k)]};
            if (sgn && n == 1) val = {{56{val[7]}}, val[7:0]};
            if (sgn && n == 2) val = {{48{val[15]}}, val[15:0]};
            ref_rdata = val;
        end
        mask = (n >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        b.addr = addr; b.rw = !wr; b.mode = (n == 8) ? 2'b10 : mode;
        b.data = (n == 8) ? wdata[63:32] : (wdata[31:0] & mask);
        beat_q.push_back(b);
        if (n == 8 && !sa && !sr) begin
            b.addr = addr + 8'd4; b.data = wdata[31:0];
            beat_q.push_back(b);
        end
        if (sa)          lat = T;
        else if (sr)     lat = d + 1 + T;
        else if (n == 8) lat = 2 * d + rd + 3;
        else             lat = d + 1;
        r.err = sa | sr; r.rdata = ref_rdata; r.lat = lat;
        sb.push_back(r);

        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_mode = mode;
        bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wdata;
        @(negedge Clk);
        acc_cyc = cyc;
        if (!hold) bus.req_valid = 1'b0;
        check("busy_after_accept", 64'(bus.busy), 64'd1);

        if (rst_b2) begin
            for (i = 0; i < 100 && !(bus.Enable && bus.Address == addr + 8'd4); i++) @(negedge Clk);
            if (i == 100) begin tests++; fails++; $display("FAIL beat2_wait: got no beat 2 expected one"); end
            #2 Reset = 1'b1;
            #1 check_reset_state("midreset");
            void'(sb.pop_back());
            ref_rdata = 64'b0;
            @(negedge Clk);
            Reset = 1'b0;
            bus.req_valid = 1'b0;
            return;
        end

        for (i = 0; i < 200 && !bus.done; i++) @(negedge Clk);
        if (i == 200) begin tests++; fails++; $display("FAIL done_wait: got no done expected done"); end
        bus.req_valid = 1'b0;
        if (sa) check("timeout_enable_low", 64'(bus.Enable), 64'd0);
        stuck_asr = 1'b0; stuck_rel = 1'b0;
    endtask

    initial begin : main
        logic [1:0] m;
        bit sr;
        tests = 0; fails = 0; cyc = 0; acc_cyc = 0;
        moc_delay = 0; rel_delay = 0; stuck_asr = 0; stuck_rel = 0;
        ref_rdata = 64'b0;
        for (int k = 0; k < 256; k++) begin
            ram_mem[k] = 8'($urandom);
            ref_mem[k] = ram_mem[k];
        end
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_mode = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 8'h00; bus.req_wdata = 64'b0;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check_reset_state("reset");
        Reset = 1'b0;
        @(negedge Clk);

        do_txn(1'b1, 2'b00, 1'b0, 8'h10, 64'hA5, 2, 1, 0, 0, 0, 0);
        do_txn(1'b0, 2'b00, 1'b1, 8'h10, 64'h0, 1, 0, 0, 0, 0, 0);
        check("signed_byte_ref", ref_rdata, 64'hFFFF_FFFF_FFFF_FFA5);
        do_txn(1'b0, 2'b00, 1'b0, 8'h10, 64'h0, 1, 0, 0, 0, 0, 0);
        do_txn(1'b1, 2'b11, 1'b0, 8'hFE, 64'h1122_3344_5566_7788, 1, 2, 0, 0, 0, 0);
        do_txn(1'b0, 2'b11, 1'b0, 8'hFE, 64'h0, 0, 0, 0, 0, 0, 0);
        check("dword_wrap_ref", ref_rdata, 64'h1122_3344_5566_7788);
        do_txn(1'b0, 2'b01, 1'b1, 8'h33, 64'h0, 0, 0, 1, 0, 0, 0);
        do_txn(1'b0, 2'b11, 1'b0, 8'h40, 64'h0, 6, 1, 0, 0, 0, 1);
        do_txn(1'b0, 2'b10, 1'b0, 8'h40, 64'h0, 1, 1, 0, 0, 0, 0);
        do_txn(1'b0, 2'b10, 1'b1, 8'h80, 64'h0, 2, 0, 0, 0, 1, 0);
        do_txn(1'b0, 2'b00, 1'b0, 8'h81, 64'h0, 0, 0, 0, 0, 0, 0);
        do_txn(1'b1, 2'b11, 1'b0, 8'h20, 64'hDEAD_BEEF_CAFE_F00D, 0, 1, 0, 1, 0, 0);

        for (int t = 0; t < 150; t++) begin
            m  = 2'($urandom_range(0, 3));
            sr = (m == 2'b11) && ($urandom_range(0, 7) == 0);
            do_txn(1'($urandom), m, 1'($urandom), 8'($urandom), {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 15) == 0), sr, ($urandom_range(0, 3) == 0), 0);
        end

        repeat (20) @(negedge Clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("beats_drained", 64'(beat_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
